// File: rtl/div_seq_if.sv
// E-stage <-> divide sequencer connection: operation request, flush/stall
// controls, stall request and held quotient/remainder.
interface div_seq_if;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        annul_i;
  logic        pipe_stall_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] quo_o;
  logic [31:0] rem_o;
  logic [1:0]  state_o;

  // Handshake: start_i is a level request held for the whole time the
  // instruction sits in E. busy_o stalls E until the result is ready.
  // done_o marks quo_o/rem_o valid, and stays high while pipe_stall_i holds E.
  // annul_i kills the request unconditionally.
  modport master (
    output start_i, signed_i, opa_i, opb_i, annul_i, pipe_stall_i,
    input  busy_o, done_o, quo_o, rem_o, state_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, annul_i, pipe_stall_i,
    output busy_o, done_o, quo_o, rem_o, state_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring 32-bit divider (DIV/DIVU) for the E stage.
// Holds the quotient and remainder until the instruction leaves E.
module div_seq (
  input logic     clk,
  input logic     resetn,
  div_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] r_q, r_d;
  logic [31:0] q_q, q_d;
  logic [31:0] div_q, div_d;
  logic        nq_q, nq_d;
  logic        nr_q, nr_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        fit;
  logic [31:0] r_next;
  logic [31:0] q_next;

  always_comb begin
    abs_a = (bus.signed_i && bus.opa_i[31]) ? (32'd0 - bus.opa_i) : bus.opa_i;
    abs_b = (bus.signed_i && bus.opb_i[31]) ? (32'd0 - bus.opb_i) : bus.opb_i;

    // Partial remainder is always below the divisor, so the shifted value fits 33 bits.
    shifted = {r_q, q_q[31]};
    trial   = shifted - {1'b0, div_q};
    fit     = ~trial[32];
    r_next  = fit ? trial[31:0] : shifted[31:0];
    q_next  = {q_q[30:0], fit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    div_d   = div_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          r_d     = 32'd0;
          q_d     = abs_a;
          div_d   = abs_b;
          nq_d    = bus.signed_i & (bus.opa_i[31] ^ bus.opb_i[31]);
          nr_d    = bus.signed_i & bus.opa_i[31];
          cnt_d   = 5'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
          if (!bus.annul_i) begin
            quo_d = nq_q ? (32'd0 - q_next) : q_next;
            rem_d = nr_q ? (32'd0 - r_next) : r_next;
          end
        end
      end
      S_DONE: begin
        // The held result is released only once E advances.
        if (!bus.pipe_stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.annul_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      r_q     <= 32'd0;
      q_q     <= 32'd0;
      div_q   <= 32'd0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      div_q   <= div_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  // Stall is combinational so E is held in the very cycle the divide starts.
  assign bus.busy_o  = ~bus.annul_i &
                       (((state_q == S_IDLE) & bus.start_i) | (state_q == S_BUSY));
  assign bus.done_o  = (state_q == S_DONE);
  assign bus.quo_o   = quo_q;
  assign bus.rem_o   = rem_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, annul,
// pipeline stall hold, back-to-back issue and mid-operation reset.
module tb_div_seq;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_q[$];

  div_seq_if bus ();

  div_seq dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.start_i  = 1'b1;
    bus.signed_i = sgn;
    bus.opa_i    = a;
    bus.opb_i    = b;
  endtask

  // Called in the cycle the request is presented in IDLE; returns in the first DONE cycle.
  task automatic measure(input string tag, input logic [31:0] eq, input logic [31:0] er);
    int n;
    n = 0;
    exp_q.push_back(eq);
    exp_q.push_back(er);
    #1;
    chk({tag, " busy_at_start"}, {31'd0, bus.busy_o}, 32'd1);
    while (bus.busy_o && n < 100) begin
      n++;
      tick();
    end
    chk({tag, " busy_cycles"}, n, 32'd33);
    chk({tag, " done"}, {31'd0, bus.done_o}, 32'd1);
    chk({tag, " quo"}, bus.quo_o, exp_q.pop_front());
    chk({tag, " rem"}, bus.rem_o, exp_q.pop_front());
  endtask

  task automatic leave(input string tag);
    bus.start_i = 1'b0;
    tick();
    chk({tag, " done_after_leave"}, {31'd0, bus.done_o}, 32'd0);
    chk({tag, " idle_after_leave"}, {30'd0, bus.state_o}, 32'd0);
  endtask

  initial begin
    int dn;
    int bsy;
    n_cmp = 0;
    n_err = 0;
    resetn           = 1'b0;
    bus.start_i      = 1'b0;
    bus.signed_i     = 1'b0;
    bus.opa_i        = 32'd0;
    bus.opb_i        = 32'd0;
    bus.annul_i      = 1'b0;
    bus.pipe_stall_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy",  {31'd0, bus.busy_o}, 32'd0);
    chk("rst done",  {31'd0, bus.done_o}, 32'd0);
    chk("rst quo",   bus.quo_o, 32'd0);
    chk("rst rem",   bus.rem_o, 32'd0);
    chk("rst state", {30'd0, bus.state_o}, 32'd0);
    resetn = 1'b1;
    tick();

    begin_div(1'b0, 32'd100, 32'd7);
    measure("divu_100_7", 32'd14, 32'd2);
    leave("divu_100_7");

    begin_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    measure("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    leave("div_m7_2");

    begin_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    measure("div_7_m2", 32'hFFFF_FFFD, 32'd1);
    leave("div_7_m2");

    begin_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    measure("div_ovf", 32'h8000_0000, 32'd0);
    leave("div_ovf");

    begin_div(1'b0, 32'h1234_5678, 32'd0);
    measure("divu_by0", 32'hFFFF_FFFF, 32'h1234_5678);
    leave("divu_by0");

    // Annul on the 10th BUSY cycle.
    begin_div(1'b0, 32'd1000, 32'd3);
    #1;
    repeat (10) tick();
    chk("annul in_busy", {30'd0, bus.state_o}, 32'd1);
    bus.annul_i = 1'b1;
    #1;
    chk("annul busy_low", {31'd0, bus.busy_o}, 32'd0);
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk("annul idle", {30'd0, bus.state_o}, 32'd0);
    chk("annul done", {31'd0, bus.done_o}, 32'd0);
    chk("annul quo_kept", bus.quo_o, 32'hFFFF_FFFF);
    chk("annul rem_kept", bus.rem_o, 32'h1234_5678);
    tick();
    begin_div(1'b0, 32'd9, 32'd3);
    measure("divu_9_3", 32'd3, 32'd0);
    leave("divu_9_3");

    // Hold in DONE for 5 stalled cycles with start still high, then back-to-back issue.
    begin_div(1'b0, 32'd50, 32'd6);
    measure("divu_50_6", 32'd8, 32'd2);
    dn  = 0;
    bsy = 0;
    while (bus.done_o && dn < 20) begin
      dn++;
      bus.pipe_stall_i = (dn <= 5);
      #1;
      if (bus.busy_o) bsy++;
      tick();
    end
    bus.pipe_stall_i = 1'b0;
    chk("stall done_cycles", dn, 32'd6);
    chk("stall busy_seen", bsy, 32'd0);
    chk("stall idle_after", {30'd0, bus.state_o}, 32'd0);
    chk("stall quo_held", bus.quo_o, 32'd8);
    begin_div(1'b0, 32'd81, 32'd9);
    measure("b2b_81_9", 32'd9, 32'd0);
    leave("b2b_81_9");

    // Reset on BUSY cycle 17, then a fresh operation with start held high.
    begin_div(1'b0, 32'h0000_FFFF, 32'h10);
    #1;
    repeat (17) tick();
    chk("rstmid in_busy", {30'd0, bus.state_o}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rstmid quo",   bus.quo_o, 32'd0);
    chk("rstmid rem",   bus.rem_o, 32'd0);
    chk("rstmid done",  {31'd0, bus.done_o}, 32'd0);
    chk("rstmid state", {30'd0, bus.state_o}, 32'd0);
    chk("rstmid busy_follows_start", {31'd0, bus.busy_o}, 32'd1);
    tick();
    resetn = 1'b1;
    measure("after_rst", 32'h0000_0FFF, 32'h0000_000F);
    leave("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
